// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and widths for the pipeline hazard controller.
package hazard_pkg;
    typedef enum logic {HZ_RUN, HZ_MC_BUSY} hz_state_t;
    localparam int PERF_W = 32;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a Decode source that depends on a load still in Execute.
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic             rs1_used_d,
    input  logic             rs2_used_d,
    input  logic [REG_W-1:0] rd_e,
    input  logic             load_e,
    input  logic             regwrite_e,
    output logic             lu_hazard
);
    assign lu_hazard = load_e && regwrite_e && (rd_e != '0) &&
                       ((rs1_used_d && rs1_d == rd_e) || (rs2_used_d && rs2_d == rd_e));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-stage stall/flush for load-use, redirect, multi-cycle ops and memory wait.
// Optional perf counters enabled with HAZARD_PERF_EN.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int MC_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic             rs1_used_d,
    input  logic             rs2_used_d,
    input  logic [REG_W-1:0] rd_e,
    input  logic             load_e,
    input  logic             regwrite_e,
    input  logic             branch_taken_e,
    input  logic             mc_start_e,
    input  logic             mc_done,
    input  logic             mem_busy,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             mc_timeout,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
);
    localparam int CNT_W = $clog2(MC_TIMEOUT + 1);

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] mc_cnt_q, mc_cnt_d;
    logic             done_pend_q, done_pend_d;
    logic             mc_timeout_q, mc_timeout_d;
    logic             lu_hazard;
    logic             busy;

    load_use_detect #(.REG_W(REG_W)) u_lu (
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .rs1_used_d (rs1_used_d),
        .rs2_used_d (rs2_used_d),
        .rd_e       (rd_e),
        .load_e     (load_e),
        .regwrite_e (regwrite_e),
        .lu_hazard  (lu_hazard)
    );

    assign busy = state_q == HZ_MC_BUSY;

    always_comb begin
        {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m} = '0;
        state_d      = state_q;
        done_pend_d  = done_pend_q;
        mc_timeout_d = mc_timeout_q;
        // Saturate so a long memory freeze cannot wrap the timeout counter.
        mc_cnt_d     = (busy && mc_cnt_q != CNT_W'(MC_TIMEOUT)) ? mc_cnt_q + CNT_W'(1) : mc_cnt_q;
        if (mem_busy) begin
            {stall_f, stall_d, stall_e, stall_m} = '1;
            done_pend_d = done_pend_q || (busy && mc_done);
        end else if (busy) begin
            if (mc_done || done_pend_q) begin
                state_d     = HZ_RUN;
                done_pend_d = 1'b0;
            end else if (mc_cnt_q >= CNT_W'(MC_TIMEOUT - 1)) begin
                state_d      = HZ_RUN;
                mc_timeout_d = 1'b1;
                flush_e      = 1'b1;
            end else begin
                {stall_f, stall_d, stall_e, flush_m} = '1;
            end
        end else if (mc_start_e) begin
            {stall_f, stall_d, stall_e, flush_m} = '1;
            state_d  = HZ_MC_BUSY;
            mc_cnt_d = '0;
        end else if (branch_taken_e) begin
            {flush_d, flush_e} = '1;
        end else if (lu_hazard) begin
            {stall_f, stall_d, flush_e} = '1;
        end
        if (reset) begin
            {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m} = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HZ_RUN;
            mc_cnt_q     <= '0;
            done_pend_q  <= 1'b0;
            mc_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mc_cnt_q     <= mc_cnt_d;
            done_pend_q  <= done_pend_d;
            mc_timeout_q <= mc_timeout_d;
        end
    end

    assign mc_timeout = mc_timeout_q && !reset;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = (stall_f && !(&perf_stall_q)) ? perf_stall_q + PERF_W'(1) : perf_stall_q;
        perf_flush_d = ((flush_d || flush_e || flush_m) && !(&perf_flush_q)) ?
                       perf_flush_q + PERF_W'(1) : perf_flush_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = reset ? 32'h0 : perf_stall_q;
    assign perf_flush_cnt = reset ? 32'h0 : perf_flush_q;
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors for pipe_hazard_ctrl with MC_TIMEOUT=8.
// Output vector order: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, mc_timeout}.
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_d, rs2_d, rd_e;
    logic        rs1_used_d, rs2_used_d, load_e, regwrite_e;
    logic        branch_taken_e, mc_start_e, mc_done, mem_busy;
    logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, mc_timeout;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
    logic [7:0]  outs;
    int          n_chk = 0;
    int          n_err = 0;

    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_LU   = 8'b1100_0100;
    localparam logic [7:0] O_BR   = 8'b0000_1100;
    localparam logic [7:0] O_MC   = 8'b1110_0010;
    localparam logic [7:0] O_MEM  = 8'b1111_0000;
    localparam logic [7:0] O_TMO  = 8'b0000_0100;
`ifdef HAZARD_PERF_EN
    localparam logic [31:0] PERF_EXP = 32'd6;
`else
    localparam logic [31:0] PERF_EXP = 32'd0;
`endif

    pipe_hazard_ctrl #(.REG_W(5), .MC_TIMEOUT(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .rs1_d          (rs1_d),
        .rs2_d          (rs2_d),
        .rs1_used_d     (rs1_used_d),
        .rs2_used_d     (rs2_used_d),
        .rd_e           (rd_e),
        .load_e         (load_e),
        .regwrite_e     (regwrite_e),
        .branch_taken_e (branch_taken_e),
        .mc_start_e     (mc_start_e),
        .mc_done        (mc_done),
        .mem_busy       (mem_busy),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .stall_e        (stall_e),
        .stall_m        (stall_m),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .flush_m        (flush_m),
        .mc_timeout     (mc_timeout),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    assign outs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, mc_timeout};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_in();
        {rs1_d, rs2_d, rd_e} = '0;
        {rs1_used_d, rs2_used_d, load_e, regwrite_e} = '0;
        {branch_taken_e, mc_start_e, mc_done, mem_busy} = '0;
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        load_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; rs1_used_d = 1'b1;
        cyc(); #1;
        check("rst_outs", {24'h0, outs}, {24'h0, O_NONE});
        check("rst_perf_s", perf_stall_cnt, 32'h0);
        check("rst_perf_f", perf_flush_cnt, 32'h0);
        clear_in();
        reset = 1'b0;
        cyc(); #1;
        check("idle", {24'h0, outs}, {24'h0, O_NONE});
        // load-use on rs1
        load_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; rs1_used_d = 1'b1;
        cyc(); #1;
        check("lu_rs1", {24'h0, outs}, {24'h0, O_LU});
        rd_e = 5'd0; rs1_d = 5'd0;
        cyc(); #1;
        check("lu_rd0", {24'h0, outs}, {24'h0, O_NONE});
        rd_e = 5'd7; rs1_d = 5'd1; rs2_d = 5'd7; rs2_used_d = 1'b1;
        cyc(); #1;
        check("lu_rs2", {24'h0, outs}, {24'h0, O_LU});
        rs2_used_d = 1'b0;
        cyc(); #1;
        check("lu_unused", {24'h0, outs}, {24'h0, O_NONE});
        regwrite_e = 1'b1; rs2_used_d = 1'b1; load_e = 1'b0;
        cyc(); #1;
        check("lu_noload", {24'h0, outs}, {24'h0, O_NONE});
        // branch overrides load-use
        load_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; rs1_used_d = 1'b1; branch_taken_e = 1'b1;
        cyc(); #1;
        check("br_over_lu", {24'h0, outs}, {24'h0, O_BR});
        branch_taken_e = 1'b0; mem_busy = 1'b1;
        cyc(); #1;
        check("mem_over_lu", {24'h0, outs}, {24'h0, O_MEM});
        clear_in();
        mc_done = 1'b1;
        cyc(); #1;
        check("done_in_run", {24'h0, outs}, {24'h0, O_NONE});
        mc_done = 1'b0;
        cyc(); #1;
        check("done_in_run2", {24'h0, outs}, {24'h0, O_NONE});
        // multi-cycle op with perf counters starting from a fresh reset
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        mc_start_e = 1'b1; branch_taken_e = 1'b1; #1;
        check("mc_start", {24'h0, outs}, {24'h0, O_MC});
        for (int i = 0; i < 5; i++) begin
            cyc();
            mc_start_e = 1'b0; branch_taken_e = 1'b0; #1;
            check($sformatf("mc_busy%0d", i), {24'h0, outs}, {24'h0, O_MC});
        end
        cyc();
        mc_done = 1'b1; #1;
        check("mc_release", {24'h0, outs}, {24'h0, O_NONE});
        cyc();
        mc_done = 1'b0; #1;
        check("mc_run", {24'h0, outs}, {24'h0, O_NONE});
        check("perf_stall", perf_stall_cnt, PERF_EXP);
        check("perf_flush", perf_flush_cnt, PERF_EXP);
        // memory wait during multi-cycle op with done arriving mid-freeze
        mc_start_e = 1'b1; #1;
        check("mc2_start", {24'h0, outs}, {24'h0, O_MC});
        cyc();
        mc_start_e = 1'b0; #1;
        check("mc2_busy", {24'h0, outs}, {24'h0, O_MC});
        for (int i = 0; i < 3; i++) begin
            cyc();
            mem_busy = 1'b1; mc_done = (i == 1); #1;
            check($sformatf("mc2_mem%0d", i), {24'h0, outs}, {24'h0, O_MEM});
        end
        cyc();
        mem_busy = 1'b0; mc_done = 1'b0; #1;
        check("mc2_release", {24'h0, outs}, {24'h0, O_NONE});
        cyc(); #1;
        check("mc2_run", {24'h0, outs}, {24'h0, O_NONE});
        // timeout after 8 cycles in MC_BUSY
        mc_start_e = 1'b1; #1;
        check("tmo_start", {24'h0, outs}, {24'h0, O_MC});
        for (int i = 0; i < 7; i++) begin
            cyc();
            mc_start_e = 1'b0; #1;
            check($sformatf("tmo_busy%0d", i), {24'h0, outs}, {24'h0, O_MC});
        end
        cyc(); #1;
        check("tmo_flush", {24'h0, outs}, {24'h0, O_TMO});
        cyc(); #1;
        check("tmo_sticky", {24'h0, outs}, {24'h0, 8'b0000_0001});
        branch_taken_e = 1'b1;
        cyc(); #1;
        check("tmo_keep", {24'h0, outs}, {24'h0, 8'b0000_1101});
        branch_taken_e = 1'b0;
        // reset mid-busy
        mc_start_e = 1'b1;
        cyc();
        mc_start_e = 1'b0; #1;
        check("rb_busy", {24'h0, outs}, {24'h0, 8'b1110_0011});
        reset = 1'b1; #1;
        check("rb_reset", {24'h0, outs}, {24'h0, O_NONE});
        cyc();
        reset = 1'b0; #1;
        check("rb_run", {24'h0, outs}, {24'h0, O_NONE});
        cyc(); #1;
        check("rb_run2", {24'h0, outs}, {24'h0, O_NONE});
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
